io_output_bank: RTL

// - Memory-mapped output port bank on the CPU I/O bus: NPORTS registers, DW bits each, driving

---
 rtl/io_output_bank.sv | 134 +++++++++++++
 1 files changed

// File: rtl/io_output_bank.sv
// Memory-mapped output port bank with byte lanes, set/clear/toggle writes and readback.
// Optional shadow buffering with a single commit address: OUT_SHADOW_EN.
module io_output_bank #(
    parameter int          NPORTS    = 4,
    parameter int          DW        = 32,
    parameter logic [1:0]  REGION    = 2'b10,
    parameter logic [31:0] RESET_VAL = '0
) (
    input  logic                 io_clk,
    input  logic                 resetn,
    input  logic [31:0]          addr,
    input  logic [31:0]          datain,
    input  logic [3:0]           byte_en,
    input  logic                 write_io_enable,
    input  logic                 read_io_enable,
    output logic [31:0]          rdata,
    output logic                 rvalid,
    output logic [NPORTS*DW-1:0] out_ports,
    output logic [NPORTS-1:0]    port_upd
);

    localparam int          NL = DW / 8;
    localparam logic [2:0]  NP = 3'(NPORTS);
    localparam logic [DW-1:0] RST = RESET_VAL[DW-1:0];

    typedef logic [DW-1:0] word_t;

    function automatic word_t merge(word_t cur, logic [31:0] din,
                                    logic [3:0] be, logic [1:0] mode);
        word_t r;
        r = cur;
        for (int b = 0; b < NL; b++) begin
            if (be[b]) begin
                case (mode)
                    2'b00:   r[8*b +: 8] = din[8*b +: 8];
                    2'b01:   r[8*b +: 8] = cur[8*b +: 8] | din[8*b +: 8];
                    2'b10:   r[8*b +: 8] = cur[8*b +: 8] & ~din[8*b +: 8];
                    default: r[8*b +: 8] = cur[8*b +: 8] ^ din[8*b +: 8];
                endcase
            end
        end
        return r;
    endfunction

    logic [1:0] idx;
    logic [1:0] mode;
    logic       hit;
    logic       sel_ok;
    logic       wr_hit;

    assign idx    = addr[3:2];
    assign mode   = addr[5:4];
    assign hit    = (addr[7:6] == REGION);
    assign sel_ok = hit && ({1'b0, idx} < NP);
    assign wr_hit = write_io_enable && sel_ok;

    logic unused_addr;
    assign unused_addr = ^{addr[31:8], addr[1:0]};

    word_t       out_q   [NPORTS];
    word_t       out_nxt [NPORTS];
    word_t       wr_cur  [NPORTS];
    word_t       wr_nxt  [NPORTS];
    word_t       rd_val;
    logic [31:0] rdata_nxt;

    // wr_cur is whatever register set writes and readback act on
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NPORTS; i++) begin
            wr_nxt[i] = wr_cur[i];
            if (idx == 2'(i)) begin
                rd_val = wr_cur[i];
                if (wr_hit)
                    wr_nxt[i] = merge(wr_cur[i], datain, byte_en, mode);
            end
        end
        rdata_nxt = sel_ok ? 32'(rd_val) : 32'h0;
    end

`ifdef OUT_SHADOW_EN
    word_t shd_q [NPORTS];
    logic  commit;

    assign commit = write_io_enable && (addr[7:6] == ~REGION) &&
                    (addr[5:2] == 4'b0);

    always_comb begin
        for (int i = 0; i < NPORTS; i++) begin
            wr_cur[i]  = shd_q[i];
            out_nxt[i] = commit ? shd_q[i] : out_q[i];
        end
    end

    always_ff @(posedge io_clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NPORTS; i++)
                shd_q[i] <= RST;
        end else begin
            for (int i = 0; i < NPORTS; i++)
                shd_q[i] <= wr_nxt[i];
        end
    end
`else
    always_comb begin
        for (int i = 0; i < NPORTS; i++) begin
            wr_cur[i]  = out_q[i];
            out_nxt[i] = wr_nxt[i];
        end
    end
`endif

    always_ff @(posedge io_clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NPORTS; i++)
                out_q[i] <= RST;
            port_upd <= '0;
            rdata    <= '0;
            rvalid   <= 1'b0;
        end else begin
            for (int i = 0; i < NPORTS; i++) begin
                out_q[i]    <= out_nxt[i];
                port_upd[i] <= (out_nxt[i] != out_q[i]);
            end
            rdata  <= read_io_enable ? rdata_nxt : 32'h0;
            rvalid <= read_io_enable;
        end
    end

    for (genvar g = 0; g < NPORTS; g++) begin : g_out
        assign out_ports[g*DW +: DW] = out_q[g];
    end

endmodule
